// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared types and constants for the CPU memory-bus arbiter.
package mips_bus_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    typedef logic owner_t;

    localparam int BUS_DATA_W = 32;
    localparam int BUS_BE_W   = 4;

    // Read data handed to a master whose transfer was aborted by the timeout.
    localparam logic [BUS_DATA_W-1:0] ABORT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mips_bus_rr_pick.sv
// mips_bus_rr_pick: two-requester round-robin pick, combinational.
//   req_i         : request vector, bit n = master n
//   last_i        : master granted most recently
//   grant_valid_o : at least one request present
//   grant_id_o    : chosen master (the one not granted last when both request)
module mips_bus_rr_pick
    import mips_bus_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_i,
    output logic       grant_valid_o,
    output owner_t     grant_id_o
);

    always_comb begin
        grant_valid_o = |req_i;
        grant_id_o    = (&req_i) ? ~last_i : req_i[1];
    end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: two-master / one-slave Avalon-style bus arbiter with stall timeout.
//   clk, reset_n                 : clock and asynchronous active-low reset
//   m0_* (instruction fetch)     : read/write/addr/byteenable/writedata in, waitrequest/readdata out
//   m1_* (load/store)            : same as m0_*
//   s_*                          : slave strobes/address/lanes/data out, waitrequest/readdata in
//   timeout_err                  : one-cycle pulse after a transfer aborted by the timeout
module mips_cpu_bus_arbiter
    import mips_bus_pkg::*;
#(
    parameter int          ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 64
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [BUS_BE_W-1:0]   m0_byteenable,
    input  logic [BUS_DATA_W-1:0] m0_writedata,
    output logic                  m0_waitrequest,
    output logic [BUS_DATA_W-1:0] m0_readdata,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [BUS_BE_W-1:0]   m1_byteenable,
    input  logic [BUS_DATA_W-1:0] m1_writedata,
    output logic                  m1_waitrequest,
    output logic [BUS_DATA_W-1:0] m1_readdata,
    output logic                  s_read,
    output logic                  s_write,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [BUS_BE_W-1:0]   s_byteenable,
    output logic [BUS_DATA_W-1:0] s_writedata,
    input  logic                  s_waitrequest,
    input  logic [BUS_DATA_W-1:0] s_readdata,
    output logic                  timeout_err
);

    // A zero TIMEOUT still needs a 1-bit counter to keep the declarations legal.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t       state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [1:0] req;
    logic       grant_valid;
    owner_t     grant_id;
    logic       busy;
    logic       own_req;
    logic       abort;
    logic       own_wait;

    assign req      = {m1_read | m1_write, m0_read | m0_write};
    assign busy     = (state_q == ARB_BUSY);
    assign own_req  = req[owner_q];
    // A dropped request takes precedence over the timeout: no abort, no error pulse.
    assign abort    = busy && own_req && s_waitrequest && (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    assign own_wait = abort ? 1'b0 : s_waitrequest;

    mips_bus_rr_pick u_pick (
        .req_i         (req),
        .last_i        (last_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = abort;
        if (!busy) begin
            if (grant_valid) begin
                state_d = ARB_BUSY;
                owner_d = grant_id;
                last_d  = grant_id;
                cnt_d   = '0;
            end
        end else if (!own_req || !s_waitrequest || abort) begin
            state_d = ARB_IDLE;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Slave side follows master 0 while idle, with strobes forced low.
    always_comb begin
        s_read         = busy && (owner_q ? m1_read : m0_read);
        s_write        = busy && (owner_q ? m1_write : m0_write);
        s_addr         = (busy && owner_q) ? m1_addr : m0_addr;
        s_byteenable   = (busy && owner_q) ? m1_byteenable : m0_byteenable;
        s_writedata    = (busy && owner_q) ? m1_writedata : m0_writedata;
        m0_waitrequest = (busy && !owner_q) ? own_wait : 1'b1;
        m1_waitrequest = (busy && owner_q) ? own_wait : 1'b1;
        m0_readdata    = (abort && !owner_q) ? ABORT_RDATA : s_readdata;
        m1_readdata    = (abort && owner_q) ? ABORT_RDATA : s_readdata;
        timeout_err    = err_q;
    end

endmodule
